sa_tile_burst_gen: RTL and testbench

Parametrised tile-to-burst command generator for the systolic-array DMA path. Accepts one 2-D tile descriptor (base, row stride, row count, bytes per row) and emits a stream of AXI-style read/write burst commands, each capped at `MAX_BURST_BEATS` beats and optionally split at 4 KB boundaries. It sits between the tile scheduler and the AXI master front end and serves A, B and C tile transfers of any element or bus width.

---
 rtl/sa_tile_burst_gen.sv | 209 ++++++++++++++++++++
 tb/tb_sa_tile_burst_gen.sv | 368 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sa_tile_burst_gen.sv
// sa_tile_burst_gen: turns one 2-D tile descriptor (base, row stride, row
// count, bytes per row) into a stream of AXI-style burst commands, each at
// most MAX_BURST_BEATS beats long.
// Optional feature macro: SA_BURST_4K_SPLIT_EN -- when defined, bursts are
// additionally split so that none crosses a BOUNDARY_BYTES boundary.
module sa_tile_burst_gen #(
  parameter int AXI_ADDR_WIDTH  = 32,
  parameter int AXI_DATA_WIDTH  = 32,
  parameter int MAX_BURST_BEATS = 16,
  parameter int ROWS_W          = 8,
  parameter int BYTES_W         = 16,
  parameter int BOUNDARY_BYTES  = 4096
) (
  input  logic                      clk,
  input  logic                      rstn,
  input  logic                      desc_valid,
  output logic                      desc_ready,
  input  logic [AXI_ADDR_WIDTH-1:0] desc_base,
  input  logic [AXI_ADDR_WIDTH-1:0] desc_stride,
  input  logic [ROWS_W-1:0]         desc_rows,
  input  logic [BYTES_W-1:0]        desc_row_bytes,
  output logic                      cmd_valid,
  input  logic                      cmd_ready,
  output logic [AXI_ADDR_WIDTH-1:0] cmd_addr,
  output logic [7:0]                cmd_len,
  output logic                      cmd_last,
  output logic                      busy,
  output logic                      done,
  output logic                      err
);

  localparam int AW        = AXI_ADDR_WIDTH;
  localparam int BPB       = AXI_DATA_WIDTH / 8;
  localparam int BPB_SHIFT = $clog2(BPB);

  // A legal boundary is never smaller than one full burst, so folding it into
  // the cap leaves the cap unchanged while guarding against a misconfiguration.
  localparam int CAP_BEATS = (BOUNDARY_BYTES / BPB < MAX_BURST_BEATS) ?
                             (BOUNDARY_BYTES / BPB) : MAX_BURST_BEATS;
  localparam logic [BYTES_W-1:0] MAX_BEATS  = BYTES_W'(CAP_BEATS);
  localparam logic [AW-1:0]      ALIGN_MASK = AW'(BPB - 1);

`ifdef SA_BURST_4K_SPLIT_EN
  localparam logic [AW:0]   BND_SIZE = (AW + 1)'(BOUNDARY_BYTES);
  localparam logic [AW-1:0] BND_MASK = AW'(BOUNDARY_BYTES - 1);
`endif

  typedef enum logic [1:0] {
    S_IDLE,
    S_CALC,
    S_ISSUE,
    S_DONE
  } state_t;

  state_t              state_q, state_d;
  logic [AW-1:0]       stride_q, stride_d;
  logic [ROWS_W-1:0]   rows_q, rows_d;
  logic [BYTES_W-1:0]  row_bytes_q, row_bytes_d;
  logic [AW-1:0]       row_addr_q, row_addr_d;
  logic [AW-1:0]       addr_q, addr_d;
  logic [BYTES_W-1:0]  left_q, left_d;
  logic [ROWS_W-1:0]   row_q, row_d;
  logic [BYTES_W-1:0]  step_q, step_d;
  logic [AW-1:0]       cmd_addr_q, cmd_addr_d;
  logic [7:0]          cmd_len_q, cmd_len_d;
  logic                cmd_last_q, cmd_last_d;
  logic                err_q, err_d;

  logic [BYTES_W-1:0]  beats_left;
  logic [BYTES_W-1:0]  n_beats;
  logic [BYTES_W-1:0]  n_bytes;
  logic [BYTES_W-1:0]  left_rem;
  logic                last_row;
  logic                misaligned;
`ifdef SA_BURST_4K_SPLIT_EN
  logic [AW:0]         beats_bnd;
`endif

  // Burst sizing for the current address: beats remaining in the row, capped,
  // and (when splitting is enabled) limited to the room before the boundary.
  always_comb begin
    beats_left = left_q >> BPB_SHIFT;
    n_beats    = (beats_left > MAX_BEATS) ? MAX_BEATS : beats_left;
`ifdef SA_BURST_4K_SPLIT_EN
    beats_bnd  = (BND_SIZE - {1'b0, addr_q & BND_MASK}) >> BPB_SHIFT;
    if (beats_bnd < (AW + 1)'(n_beats)) begin
      n_beats = BYTES_W'(beats_bnd);
    end
`endif
    n_bytes    = n_beats << BPB_SHIFT;
    last_row   = (row_q == rows_q - ROWS_W'(1));
    misaligned = ((desc_base & ALIGN_MASK) != '0) ||
                 ((desc_stride & ALIGN_MASK) != '0) ||
                 ((AW'(desc_row_bytes) & ALIGN_MASK) != '0);
  end

  // Next-state and datapath updates for the descriptor walk.
  always_comb begin
    state_d     = state_q;
    stride_d    = stride_q;
    rows_d      = rows_q;
    row_bytes_d = row_bytes_q;
    row_addr_d  = row_addr_q;
    addr_d      = addr_q;
    left_d      = left_q;
    row_d       = row_q;
    step_d      = step_q;
    cmd_addr_d  = cmd_addr_q;
    cmd_len_d   = cmd_len_q;
    cmd_last_d  = cmd_last_q;
    err_d       = err_q;
    left_rem    = left_q - step_q;

    case (state_q)
      S_IDLE: begin
        if (desc_valid) begin
          stride_d    = desc_stride;
          rows_d      = desc_rows;
          row_bytes_d = desc_row_bytes;
          row_addr_d  = desc_base;
          addr_d      = desc_base;
          left_d      = desc_row_bytes;
          row_d       = '0;
          err_d       = misaligned;
          if (misaligned || (desc_rows == '0) || (desc_row_bytes == '0)) begin
            state_d = S_DONE;
          end else begin
            state_d = S_CALC;
          end
        end
      end
      S_CALC: begin
        cmd_addr_d = addr_q;
        cmd_len_d  = 8'(n_beats - BYTES_W'(1));
        cmd_last_d = last_row && (n_bytes == left_q);
        step_d     = n_bytes;
        state_d    = S_ISSUE;
      end
      S_ISSUE: begin
        if (cmd_ready) begin
          if (left_rem == '0) begin
            if (last_row) begin
              state_d = S_DONE;
            end else begin
              row_d      = row_q + ROWS_W'(1);
              row_addr_d = row_addr_q + stride_q;
              addr_d     = row_addr_q + stride_q;
              left_d     = row_bytes_q;
              state_d    = S_CALC;
            end
          end else begin
            addr_d  = addr_q + AW'(step_q);
            left_d  = left_rem;
            state_d = S_CALC;
          end
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and datapath registers; reset discards any in-flight descriptor.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q     <= S_IDLE;
      stride_q    <= '0;
      rows_q      <= '0;
      row_bytes_q <= '0;
      row_addr_q  <= '0;
      addr_q      <= '0;
      left_q      <= '0;
      row_q       <= '0;
      step_q      <= '0;
      cmd_addr_q  <= '0;
      cmd_len_q   <= '0;
      cmd_last_q  <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      stride_q    <= stride_d;
      rows_q      <= rows_d;
      row_bytes_q <= row_bytes_d;
      row_addr_q  <= row_addr_d;
      addr_q      <= addr_d;
      left_q      <= left_d;
      row_q       <= row_d;
      step_q      <= step_d;
      cmd_addr_q  <= cmd_addr_d;
      cmd_len_q   <= cmd_len_d;
      cmd_last_q  <= cmd_last_d;
      err_q       <= err_d;
    end
  end

  assign desc_ready = (state_q == S_IDLE);
  assign busy       = (state_q != S_IDLE);
  assign cmd_valid  = (state_q == S_ISSUE);
  assign done       = (state_q == S_DONE);
  assign cmd_addr   = cmd_addr_q;
  assign cmd_len    = cmd_len_q;
  assign cmd_last   = cmd_last_q;
  assign err        = err_q;

endmodule

// File: tb/tb_sa_tile_burst_gen.sv
// Testbench for sa_tile_burst_gen: directed tiles plus randomized descriptors
// and backpressure checked against a behavioural burst-splitting model.
module tb_sa_tile_burst_gen;

  localparam int BPB   = 4;
  localparam int MAXB  = 16;
  localparam int BOUND = 4096;

  logic        clk;
  logic        rstn;
  logic        desc_valid;
  logic        desc_ready;
  logic [31:0] desc_base;
  logic [31:0] desc_stride;
  logic [7:0]  desc_rows;
  logic [15:0] desc_row_bytes;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [31:0] cmd_addr;
  logic [7:0]  cmd_len;
  logic        cmd_last;
  logic        busy;
  logic        done;
  logic        err;

  int checks = 0;
  int errors = 0;

  logic [31:0] obs_addr[$];
  logic [7:0]  obs_len[$];
  bit          obs_last[$];
  int          hs_cyc[$];
  logic [31:0] exp_addr[$];
  logic [7:0]  exp_len[$];
  bit          exp_last[$];
  bit          exp_err;

  int first_lat;
  int done_cyc;
  int unstable;
  int held;
  bit timed_out;
  bit accept_ready;
  bit err_after;
  bit ready_after_done;
  bit done_after;

  sa_tile_burst_gen dut (
    .clk            (clk),
    .rstn           (rstn),
    .desc_valid     (desc_valid),
    .desc_ready     (desc_ready),
    .desc_base      (desc_base),
    .desc_stride    (desc_stride),
    .desc_rows      (desc_rows),
    .desc_row_bytes (desc_row_bytes),
    .cmd_valid      (cmd_valid),
    .cmd_ready      (cmd_ready),
    .cmd_addr       (cmd_addr),
    .cmd_len        (cmd_len),
    .cmd_last       (cmd_last),
    .busy           (busy),
    .done           (done),
    .err            (err)
  );

  // Free-running clock, period 10.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: walk each row and peel off bursts by plain arithmetic.
  task automatic model(input logic [31:0] base, input logic [31:0] stride,
                       input logic [7:0] rows, input logic [15:0] rb);
    logic [31:0] a;
    int left;
    int n;
    int room;
    exp_addr.delete(); exp_len.delete(); exp_last.delete();
    exp_err = (base % BPB != 0) || (stride % BPB != 0) || (rb % BPB != 0);
    if (exp_err || rows == 0 || rb == 0) return;
    for (int r = 0; r < rows; r++) begin
      a = base + stride * 32'(r);
      left = int'(rb);
      while (left > 0) begin
        n = left / BPB;
        if (n > MAXB) n = MAXB;
        room = (BOUND - int'(a % BOUND)) / BPB;
`ifdef SA_BURST_4K_SPLIT_EN
        if (room < n) n = room;
`endif
        exp_addr.push_back(a);
        exp_len.push_back(8'(n - 1));
        exp_last.push_back((r == rows - 1) && (n * BPB == left));
        a = a + 32'(n * BPB);
        left = left - n * BPB;
      end
    end
  endtask

  // Present one descriptor and record everything the DUT does until done.
  task automatic run_desc(input logic [31:0] base, input logic [31:0] stride,
                          input logic [7:0] rows, input logic [15:0] rb,
                          input int ready_pct, input int hold_cmd);
    int c;
    bit got_done;
    bit prev_pend;
    logic [31:0] pa;
    logic [7:0] pl;
    logic pla;
    obs_addr.delete(); obs_len.delete(); obs_last.delete(); hs_cyc.delete();
    first_lat = -1; done_cyc = -1; unstable = 0; held = 0;
    got_done = 0; prev_pend = 0; pa = '0; pl = '0; pla = 1'b0;
    @(negedge clk);
    desc_valid = 1'b1; desc_base = base; desc_stride = stride;
    desc_rows = rows; desc_row_bytes = rb;
    accept_ready = desc_ready;
    @(posedge clk);
    @(negedge clk);
    desc_valid = 1'b0;
    desc_base = $urandom; desc_stride = $urandom;
    err_after = err;
    c = 1;
    while (!got_done && c < 3000) begin
      if (prev_pend && (!cmd_valid || cmd_addr !== pa || cmd_len !== pl || cmd_last !== pla))
        unstable++;
      if (cmd_valid && first_lat < 0) first_lat = c;
      if (done) begin
        done_cyc = c;
        got_done = 1;
      end else begin
        if (cmd_valid && obs_addr.size() == hold_cmd && held < 5) begin
          cmd_ready = 1'b0;
          held++;
        end else begin
          cmd_ready = ($urandom_range(99) < ready_pct);
        end
        if (cmd_valid && cmd_ready) begin
          obs_addr.push_back(cmd_addr);
          obs_len.push_back(cmd_len);
          obs_last.push_back(cmd_last);
          hs_cyc.push_back(c);
          prev_pend = 0;
        end else begin
          prev_pend = cmd_valid;
          pa = cmd_addr; pl = cmd_len; pla = cmd_last;
        end
        @(posedge clk);
        @(negedge clk);
        c++;
      end
    end
    cmd_ready = 1'b0;
    timed_out = !got_done;
    @(posedge clk);
    @(negedge clk);
    ready_after_done = desc_ready;
    done_after = done;
  endtask

  task automatic test_reset();
    #1;
    checks++; if ({cmd_valid, cmd_last, busy, done, err} !== 5'b0) begin
      errors++; $display("[TB] FAIL reset_flags: got %b want 00000", {cmd_valid, cmd_last, busy, done, err});
    end
    checks++; if (cmd_addr !== 32'h0 || cmd_len !== 8'h0) begin
      errors++; $display("[TB] FAIL reset_fields: got addr %h len %h want 0/0", cmd_addr, cmd_len);
    end
    @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);
    checks++; if (desc_ready !== 1'b1 || busy !== 1'b0) begin
      errors++; $display("[TB] FAIL reset_ready: got ready %b busy %b want 1/0", desc_ready, busy);
    end
  endtask

  task automatic test_strided(input int hold_cmd);
    run_desc(32'h1000, 32'h40, 8'd8, 16'd8, 100, hold_cmd);
    checks++; if (timed_out || !accept_ready) begin
      errors++; $display("[TB] FAIL strided_run: timeout %0b accept %0b", timed_out, accept_ready);
    end
    checks++; if (obs_addr.size() !== 8) begin
      errors++; $display("[TB] FAIL strided_count: got %0d want 8", obs_addr.size());
    end
    for (int i = 0; i < obs_addr.size() && i < 8; i++) begin
      checks++;
      if (obs_addr[i] !== 32'h1000 + 32'h40 * 32'(i) || obs_len[i] !== 8'd1 || obs_last[i] !== (i == 7)) begin
        errors++; $display("[TB] FAIL strided_cmd%0d: got %h/%0d/%0b want %h/1/%0b",
                           i, obs_addr[i], obs_len[i], obs_last[i], 32'h1000 + 32'h40 * 32'(i), i == 7);
      end
    end
    checks++; if (first_lat !== 2) begin
      errors++; $display("[TB] FAIL strided_latency: got %0d want 2", first_lat);
    end
    checks++; if (obs_addr.size() == 0 || done_cyc !== hs_cyc[hs_cyc.size() - 1] + 1) begin
      errors++; $display("[TB] FAIL strided_done: got cycle %0d want last handshake + 1", done_cyc);
    end
    checks++; if (ready_after_done !== 1'b1 || done_after !== 1'b0) begin
      errors++; $display("[TB] FAIL strided_after_done: got ready %0b done %0b want 1/0", ready_after_done, done_after);
    end
    if (hold_cmd < 0) begin
      for (int i = 1; i < hs_cyc.size(); i++) begin
        checks++; if (hs_cyc[i] - hs_cyc[i - 1] !== 2) begin
          errors++; $display("[TB] FAIL strided_throughput: gap %0d want 2", hs_cyc[i] - hs_cyc[i - 1]);
        end
      end
    end else begin
      checks++; if (held !== 5 || unstable !== 0) begin
        errors++; $display("[TB] FAIL backpressure_hold: held %0d unstable %0d want 5/0", held, unstable);
      end
    end
  endtask

  task automatic test_burst_cap();
    model(32'h0, 32'h0, 8'd1, 16'd256);
    run_desc(32'h0, 32'h0, 8'd1, 16'd256, 100, -1);
    checks++; if (obs_addr.size() !== 4 || exp_addr.size() !== 4) begin
      errors++; $display("[TB] FAIL cap_count: got %0d want 4", obs_addr.size());
    end
    for (int i = 0; i < obs_addr.size() && i < 4; i++) begin
      checks++; if (obs_addr[i] !== 32'h40 * 32'(i) || obs_len[i] !== 8'd15 || obs_last[i] !== (i == 3)) begin
        errors++; $display("[TB] FAIL cap_cmd%0d: got %h/%0d/%0b want %h/15/%0b",
                           i, obs_addr[i], obs_len[i], obs_last[i], 32'h40 * 32'(i), i == 3);
      end
    end
  endtask

  task automatic test_boundary();
    logic [31:0] want_addr[$];
    logic [7:0]  want_len[$];
`ifdef SA_BURST_4K_SPLIT_EN
    want_addr = '{32'h0FF0, 32'h1000};
    want_len  = '{8'd3, 8'd11};
`else
    want_addr = '{32'h0FF0};
    want_len  = '{8'd15};
`endif
    run_desc(32'h0FF0, 32'h0, 8'd1, 16'd64, 100, -1);
    checks++; if (obs_addr.size() !== want_addr.size()) begin
      errors++; $display("[TB] FAIL boundary_count: got %0d want %0d", obs_addr.size(), want_addr.size());
    end else begin
      for (int i = 0; i < want_addr.size(); i++) begin
        checks++; if (obs_addr[i] !== want_addr[i] || obs_len[i] !== want_len[i]) begin
          errors++; $display("[TB] FAIL boundary_cmd%0d: got %h/%0d want %h/%0d",
                             i, obs_addr[i], obs_len[i], want_addr[i], want_len[i]);
        end
      end
    end
  endtask

  task automatic test_error_zero();
    run_desc(32'h1002, 32'h40, 8'd2, 16'd8, 100, -1);
    checks++; if (err_after !== 1'b1 || obs_addr.size() !== 0 || first_lat !== -1 || done_cyc !== 1) begin
      errors++; $display("[TB] FAIL err_base: got err %0b cmds %0d done@%0d want 1/0/1", err_after, obs_addr.size(), done_cyc);
    end
    checks++; if (err !== 1'b1) begin
      errors++; $display("[TB] FAIL err_sticky: got %0b want 1", err);
    end
    run_desc(32'h2000, 32'h41, 8'd2, 16'd8, 100, -1);
    checks++; if (err_after !== 1'b1 || obs_addr.size() !== 0 || done_cyc !== 1) begin
      errors++; $display("[TB] FAIL err_stride: got err %0b cmds %0d done@%0d want 1/0/1", err_after, obs_addr.size(), done_cyc);
    end
    run_desc(32'h2000, 32'h40, 8'd1, 16'd8, 100, -1);
    checks++; if (err_after !== 1'b0 || obs_addr.size() !== 1) begin
      errors++; $display("[TB] FAIL err_clear: got err %0b cmds %0d want 0/1", err_after, obs_addr.size());
    end
    run_desc(32'h3000, 32'h40, 8'd0, 16'd8, 100, -1);
    checks++; if (err_after !== 1'b0 || obs_addr.size() !== 0 || done_cyc !== 1) begin
      errors++; $display("[TB] FAIL zero_rows: got err %0b cmds %0d done@%0d want 0/0/1", err_after, obs_addr.size(), done_cyc);
    end
  endtask

  task automatic test_reset_mid();
    int waited;
    @(negedge clk);
    desc_valid = 1'b1; desc_base = 32'h0; desc_stride = 32'h0;
    desc_rows = 8'd1; desc_row_bytes = 16'd256;
    @(posedge clk);
    @(negedge clk);
    desc_valid = 1'b0;
    cmd_ready = 1'b0;
    waited = 0;
    while (!cmd_valid && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    checks++; if (cmd_valid !== 1'b1) begin
      errors++; $display("[TB] FAIL midreset_issue: got cmd_valid %0b want 1", cmd_valid);
    end
    #2 rstn = 1'b0;
    #1;
    checks++; if ({cmd_valid, cmd_last, busy, done, err} !== 5'b0 || cmd_addr !== 32'h0 || cmd_len !== 8'h0) begin
      errors++; $display("[TB] FAIL midreset_outputs: got %b addr %h len %h want zeros",
                         {cmd_valid, cmd_last, busy, done, err}, cmd_addr, cmd_len);
    end
    @(negedge clk);
    rstn = 1'b1;
    model(32'h0, 32'h0, 8'd1, 16'd256);
    run_desc(32'h0, 32'h0, 8'd1, 16'd256, 60, -1);
    checks++; if (timed_out || obs_addr.size() !== exp_addr.size()) begin
      errors++; $display("[TB] FAIL midreset_rerun_count: got %0d want %0d", obs_addr.size(), exp_addr.size());
    end else begin
      for (int i = 0; i < exp_addr.size(); i++) begin
        checks++; if (obs_addr[i] !== exp_addr[i] || obs_len[i] !== exp_len[i] || obs_last[i] !== exp_last[i]) begin
          errors++; $display("[TB] FAIL midreset_rerun_cmd%0d: got %h/%0d/%0b want %h/%0d/%0b",
                             i, obs_addr[i], obs_len[i], obs_last[i], exp_addr[i], exp_len[i], exp_last[i]);
        end
      end
    end
  endtask

  task automatic test_random(input int count);
    logic [31:0] base;
    logic [31:0] stride;
    logic [7:0]  rows;
    logic [15:0] rb;
    int sel;
    int pct;
    for (int k = 0; k < count; k++) begin
      sel = $urandom_range(0, 3);
      base = $urandom & ~32'h3;
      if (sel == 0) base = 32'($urandom_range(1, 15)) * 32'h1000 - 32'($urandom_range(0, 40) * 4);
      if (sel == 1) base = 32'hFFFF_FFC0;
      stride = 32'($urandom_range(0, 2048) * 4);
      rows = 8'($urandom_range(0, 5));
      rb = 16'($urandom_range(0, 80) * 4);
      if ($urandom_range(0, 11) == 0) base[1] = ~base[1];
      if ($urandom_range(0, 11) == 0) rb[0] = 1'b1;
      pct = $urandom_range(30, 100);
      model(base, stride, rows, rb);
      run_desc(base, stride, rows, rb, pct, -1);
      checks++; if (timed_out || !accept_ready || err_after !== exp_err || unstable !== 0) begin
        errors++; $display("[TB] FAIL rand%0d_status: timeout %0b accept %0b err %0b want %0b unstable %0d",
                           k, timed_out, accept_ready, err_after, exp_err, unstable);
      end
      checks++; if (obs_addr.size() !== exp_addr.size()) begin
        errors++; $display("[TB] FAIL rand%0d_count: got %0d want %0d", k, obs_addr.size(), exp_addr.size());
      end else begin
        for (int i = 0; i < exp_addr.size(); i++) begin
          checks++; if (obs_addr[i] !== exp_addr[i] || obs_len[i] !== exp_len[i] || obs_last[i] !== exp_last[i]) begin
            errors++; $display("[TB] FAIL rand%0d_cmd%0d: got %h/%0d/%0b want %h/%0d/%0b",
                               k, i, obs_addr[i], obs_len[i], obs_last[i], exp_addr[i], exp_len[i], exp_last[i]);
          end
        end
      end
      checks++; if (done_cyc !== ((hs_cyc.size() == 0) ? 1 : hs_cyc[hs_cyc.size() - 1] + 1)) begin
        errors++; $display("[TB] FAIL rand%0d_done: got cycle %0d", k, done_cyc);
      end
    end
  endtask

  // Sequence every scenario, then report.
  initial begin
    rstn = 1'b0;
    desc_valid = 1'b0; desc_base = '0; desc_stride = '0;
    desc_rows = '0; desc_row_bytes = '0; cmd_ready = 1'b0;
    test_reset();
    test_strided(-1);
    test_burst_cap();
    test_boundary();
    test_error_zero();
    test_strided(3);
    test_reset_mid();
    test_random(25);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
